apb_cmd_master: RTL and testbench

- Upstream APB requester that feeds the register-file slave (cntrl at 0x0, reg1..reg4 at 0x4..0x10).
- Accepts word read/write commands on a valid/ready request port and buffers them in a small FIFO.
- Sequences each command as an APB SETUP/ACCESS transfer and returns the read data or completion as a one-cycle response pulse.

---
 rtl/apb_cmd_master.sv | 209 ++++++++++++++++++++
 tb/tb_apb_cmd_master.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: queued word read/write commands issued as APB transfers.
// Define APB_PREADY_EN to add a pready input for slave wait states.
module apb_cmd_master #(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
`ifdef APB_PREADY_EN
  input  logic              pready,
`endif
  input  logic [DATA_W-1:0] prdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  cmd_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_n;

  state_t state;
  state_t state_n;

  logic push;
  logic pop;
  logic done;
  logic ld;
  logic nxt_avail;
  cmd_t in_cmd;
  cmd_t head;
  cmd_t nxt_cmd;
  cmd_t ld_cmd;

  logic              psel_n;
  logic              pen_n;
  logic              rv_n;
  logic              re_n;
  logic              rw_n;
  logic [DATA_W-1:0] rd_n;

`ifdef APB_PREADY_EN
  assign done = pready;
`else
  assign done = 1'b1;
`endif

  assign push   = req_valid && req_ready;
  assign in_cmd = '{wr: req_write, addr: req_addr, wdata: req_wdata};
  assign head   = mem[rd_ptr];

  // Head after the in-flight pop; a same-edge push fills an otherwise empty queue.
  assign nxt_avail = (count > CW'(1)) || push;
  assign nxt_cmd   = (count > CW'(1)) ? mem[rd_ptr + PW'(1)] : in_cmd;

  // Occupancy update from push/pop.
  always_comb begin
    cnt_n = count;
    unique case (1'b1)
      push && !pop: cnt_n = count + CW'(1);
      pop && !push: cnt_n = count - CW'(1);
      default:      cnt_n = count;
    endcase
  end

  // Command storage; entries are only valid below count, so no reset.
  always_ff @(posedge pclk) begin
    if (push) begin
      mem[wr_ptr] <= in_cmd;
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count     <= cnt_n;
      req_ready <= (cnt_n != CW'(FIFO_DEPTH));
    end
  end

  // FSM state register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, pop and next values of the registered outputs.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    ld      = 1'b0;
    ld_cmd  = head;
    psel_n  = 1'b0;
    pen_n   = 1'b0;
    rv_n    = 1'b0;
    re_n    = 1'b0;
    rw_n    = rsp_write;
    rd_n    = rsp_rdata;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          if (head.addr[1:0] != 2'b00) begin
            pop  = 1'b1;
            rv_n = 1'b1;
            re_n = 1'b1;
            rw_n = head.wr;
            rd_n = '0;
          end else begin
            state_n = SETUP;
            psel_n  = 1'b1;
            ld      = 1'b1;
          end
        end
      end
      SETUP: begin
        state_n = ACCESS;
        psel_n  = 1'b1;
        pen_n   = 1'b1;
      end
      ACCESS: begin
        if (!done) begin
          psel_n = 1'b1;
          pen_n  = 1'b1;
        end else begin
          pop  = 1'b1;
          rv_n = 1'b1;
          rw_n = pwrite;
          rd_n = pwrite ? '0 : prdata;
          if (nxt_avail && nxt_cmd.addr[1:0] == 2'b00) begin
            state_n = SETUP;
            psel_n  = 1'b1;
            ld      = 1'b1;
            ld_cmd  = nxt_cmd;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered APB and response outputs; bus fields hold while idle.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      psel      <= psel_n;
      penable   <= pen_n;
      rsp_valid <= rv_n;
      rsp_err   <= re_n;
      rsp_write <= rw_n;
      rsp_rdata <= rd_n;
      if (ld) begin
        pwrite <= ld_cmd.wr;
        paddr  <= ld_cmd.addr;
        pwdata <= ld_cmd.wdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: vector table plus scoreboard for apb_cmd_master,
// with a small register-file APB slave behind it.
module tb_apb_cmd_master;

  logic        pclk;
  logic        presetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        acc_ok;
`ifdef APB_PREADY_EN
  logic        pready;
  assign acc_ok = pready;
`else
  assign acc_ok = 1'b1;
`endif

  apb_cmd_master #(
    .FIFO_DEPTH(2),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .pclk(pclk),
    .presetn(presetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_write(rsp_write),
    .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
`ifdef APB_PREADY_EN
    .pready(pready),
`endif
    .prdata(prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        w;
    logic        e;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        ee;
    logic [31:0] ed;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks;
  int   fails;
  int   rsp_seen;

  // Register-file slave: cntrl at 0x0, reg1..reg4 at 0x4..0x10.
  logic [31:0] regs [5];

  function automatic logic mapped(input logic [31:0] a);
    return (a <= 32'h10) && (a[1:0] == 2'b00);
  endfunction

  always @(posedge pclk) begin
    if (psel && !penable) begin
      prdata <= mapped(paddr) ? regs[paddr[4:2]] : 32'h0;
    end
    if (psel && penable && acc_ok && pwrite && mapped(paddr)) begin
      regs[paddr[4:2]] <= pwdata;
    end
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Response scoreboard and a basic APB sanity check.
  always @(negedge pclk) begin
    if (presetn && penable) begin
      check("penable_without_psel", {63'd0, psel}, 64'd1);
    end
    if (presetn && rsp_valid) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_rsp: got w=%0b e=%0b d=%0h expected none",
                 rsp_write, rsp_err, rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp", {30'd0, rsp_write, rsp_err, rsp_rdata},
              {30'd0, mon_e.w, mon_e.e, mon_e.d});
      end
    end
  end

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic expect_rsp(input logic w, input logic e,
                            input logic [31:0] d);
    exp_t x;
    x.w = w;
    x.e = e;
    x.d = d;
    exp_q.push_back(x);
  endtask

  // Offer one command, wait (bounded) for acceptance, queue its response.
  task automatic send(input vec_t v);
    int t;
    t = 0;
    drive(v.w, v.a, v.d);
    while (!req_ready && t < 50) begin
      cyc();
      t++;
    end
    if (!req_ready) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: got req_ready=0 expected 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge pclk);
    expect_rsp(v.w, v.ee, v.ed);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      cyc();
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    cyc();
    cyc();
  endtask

  vec_t tbl [10];
  int   mark;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{w: 1'b0, a: 32'h04, d: 32'h0, ee: 1'b0, ed: 32'hDEADBEEF};
    tbl[1] = '{w: 1'b1, a: 32'h08, d: 32'h11, ee: 1'b0, ed: 32'h0};
    tbl[2] = '{w: 1'b0, a: 32'h08, d: 32'h0, ee: 1'b0, ed: 32'h11};
    tbl[3] = '{w: 1'b0, a: 32'h20, d: 32'h0, ee: 1'b0, ed: 32'h0};
    tbl[4] = '{w: 1'b0, a: 32'h06, d: 32'h0, ee: 1'b1, ed: 32'h0};
    tbl[5] = '{w: 1'b1, a: 32'h10, d: 32'hA5A50001, ee: 1'b0, ed: 32'h0};
    tbl[6] = '{w: 1'b0, a: 32'h10, d: 32'h0, ee: 1'b0, ed: 32'hA5A50001};
    tbl[7] = '{w: 1'b1, a: 32'h03, d: 32'hFFFF, ee: 1'b1, ed: 32'h0};
    tbl[8] = '{w: 1'b0, a: 32'h00, d: 32'h0, ee: 1'b0, ed: 32'h0};
    tbl[9] = '{w: 1'b0, a: 32'h0C, d: 32'h0, ee: 1'b0, ed: 32'h0};

    checks   = 0;
    fails    = 0;
    rsp_seen = 0;
    for (int i = 0; i < 5; i++) regs[i] = 32'h0;
    prdata    = 32'h0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
`ifdef APB_PREADY_EN
    pready = 1'b1;
`endif

    // Asynchronous reset.
    presetn = 1'b1;
    #1 presetn = 1'b0;
    #2;
    check("rst_psel", {63'd0, psel}, 64'd0);
    check("rst_penable", {63'd0, penable}, 64'd0);
    check("rst_ready", {63'd0, req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    repeat (3) cyc();
    presetn = 1'b1;
    cyc();
    check("ready_after_rst", {63'd0, req_ready}, 64'd1);

    // Write 0x4: SETUP, ACCESS, response three edges after acceptance.
    drive(1'b1, 32'h4, 32'hDEADBEEF);
    cyc();
    expect_rsp(1'b1, 1'b0, 32'h0);
    req_valid = 1'b0;
    check("lat_n0_psel", {63'd0, psel}, 64'd0);
    cyc();
    check("lat_setup", {61'd0, psel, penable, pwrite}, 64'b101);
    check("lat_paddr", 64'(paddr), 64'h4);
    check("lat_pwdata", 64'(pwdata), 64'hDEADBEEF);
    cyc();
    check("lat_access", {62'd0, psel, penable}, 64'b11);
    check("lat_no_rsp", {63'd0, rsp_valid}, 64'd0);
    cyc();
    check("lat_rsp", {62'd0, rsp_valid, psel}, 64'b10);
    drain();

    // Vector table through the scoreboard.
    for (int i = 0; i < 10; i++) begin
      send(tbl[i]);
    end
    drain();

    // Back-to-back writes filling the two-entry FIFO.
    drive(1'b1, 32'h8, 32'h11);
    cyc();
    expect_rsp(1'b1, 1'b0, 32'h0);
    drive(1'b1, 32'hC, 32'h22);
    cyc();
    expect_rsp(1'b1, 1'b0, 32'h0);
    req_valid = 1'b0;
    check("b2b_full", {63'd0, req_ready}, 64'd0);
    check("b2b_setup1", {62'd0, psel, penable}, 64'b10);
    check("b2b_addr1", 64'(paddr), 64'h8);
    cyc();
    check("b2b_access1", {62'd0, psel, penable}, 64'b11);
    cyc();
    check("b2b_setup2", {62'd0, psel, penable}, 64'b10);
    check("b2b_addr2", 64'(paddr), 64'hC);
    check("b2b_rsp1", {62'd0, rsp_valid, req_ready}, 64'b11);
    cyc();
    check("b2b_access2", {62'd0, psel, penable}, 64'b11);
    check("b2b_gap", {63'd0, rsp_valid}, 64'd0);
    cyc();
    check("b2b_rsp2", {62'd0, rsp_valid, psel}, 64'b10);
    drain();

    // Misaligned read rejected, then an aligned read of cntrl.
    drive(1'b0, 32'h6, 32'h0);
    cyc();
    expect_rsp(1'b0, 1'b1, 32'h0);
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    expect_rsp(1'b0, 1'b0, 32'h0);
    req_valid = 1'b0;
    check("mis_rsp", {61'd0, rsp_valid, rsp_err, psel}, 64'b110);
    cyc();
    check("mis_next_setup", {62'd0, psel, penable}, 64'b10);
    check("mis_next_addr", 64'(paddr), 64'h0);
    cyc();
    cyc();
    check("mis_next_rsp", {62'd0, rsp_valid, rsp_err}, 64'b10);
    drain();

    check("reg_0x8", 64'(regs[2]), 64'h11);
    check("reg_0xC", 64'(regs[3]), 64'h22);

`ifdef APB_PREADY_EN
    // Wait states on a read of 0x10.
    drive(1'b0, 32'h10, 32'h0);
    cyc();
    expect_rsp(1'b0, 1'b0, 32'hA5A50001);
    req_valid = 1'b0;
    cyc();
    pready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("wait_bus", {61'd0, psel, penable, rsp_valid}, 64'b110);
      check("wait_addr", 64'(paddr), 64'h10);
    end
    pready = 1'b1;
    cyc();
    check("wait_done", {62'd0, rsp_valid, psel}, 64'b10);
    drain();
`endif

    // Reset during ACCESS of a write with a read queued behind it.
    drive(1'b1, 32'h10, 32'h77);
    cyc();
    expect_rsp(1'b1, 1'b0, 32'h0);
    drive(1'b0, 32'h4, 32'h0);
    cyc();
    expect_rsp(1'b0, 1'b0, 32'hDEADBEEF);
    req_valid = 1'b0;
    cyc();
    check("mid_access", {62'd0, psel, penable}, 64'b11);
    #2 presetn = 1'b0;
    #1;
    check("mid_rst_bus", {62'd0, psel, penable}, 64'b00);
    exp_q.delete();
    mark = rsp_seen;
    cyc();
    cyc();
    presetn = 1'b1;
    repeat (6) cyc();
    check("post_rst_no_rsp", 64'(rsp_seen - mark), 64'd0);
    check("post_rst_ready", {63'd0, req_ready}, 64'd1);
    check("post_rst_psel", {63'd0, psel}, 64'd0);
    check("reg_0x10_kept", 64'(regs[4]), 64'hA5A50001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
